// File: rtl/lsu_pkg.sv
// Shared types and constants for the MEM-stage load/store unit.
package lsu_pkg;

  typedef enum logic [1:0] {StIdle, StReq, StWait, StDone} lsu_state_e;

  // RISC-V load/store width codes
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [1:0] CAUSE_NONE     = 2'b00;
  localparam logic [1:0] CAUSE_MISALIGN = 2'b01;
  localparam logic [1:0] CAUSE_TIMEOUT  = 2'b10;
  localparam logic [1:0] CAUSE_ILLEGAL  = 2'b11;

  // Stores only allow signed-style codes; the unsigned codes exist for loads only.
  function automatic logic f3_illegal(input logic [2:0] f3, input logic is_store);
    logic ill;
    unique case (f3)
      F3_B, F3_H, F3_W: ill = 1'b0;
      F3_BU, F3_HU:     ill = is_store;
      default:          ill = 1'b1;
    endcase
    return ill;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering for the LSU: store byte enables / data replication and
// load lane extraction with sign or zero extension.
// LSU_MISALIGN_TRAP_EN: flag misaligned h/w accesses instead of force-aligning them.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  off,
  input  logic        is_store,
  input  logic [31:0] wdata_in,
  input  logic [31:0] rdata_in,
  output logic [3:0]  be,
  output logic [31:0] wdata_out,
  output logic [31:0] rdata_out,
  output logic        illegal,
  output logic        misaligned
);

  logic [1:0]  size;
  logic [1:0]  eff_off;
  logic [31:0] lane;

  // Effective lane offset and misalignment detection
  always_comb begin
    size = funct3[1:0];
`ifdef LSU_MISALIGN_TRAP_EN
    eff_off    = off;
    misaligned = ((size == 2'b01) && off[0]) || ((size == 2'b10) && (off != 2'b00));
`else
    misaligned = 1'b0;
    unique case (size)
      2'b01:   eff_off = {off[1], 1'b0};
      2'b10:   eff_off = 2'b00;
      default: eff_off = off;
    endcase
`endif
  end

  // Byte enables, store replication and load extraction
  always_comb begin
    illegal = f3_illegal(funct3, is_store);
    lane    = rdata_in >> {eff_off, 3'b000};
    unique case (size)
      2'b00: begin
        be        = 4'b0001 << eff_off;
        wdata_out = {4{wdata_in[7:0]}};
      end
      2'b01: begin
        be        = 4'b0011 << eff_off;
        wdata_out = {2{wdata_in[15:0]}};
      end
      2'b10: begin
        be        = 4'b1111;
        wdata_out = wdata_in;
      end
      default: begin
        be        = 4'b0000;
        wdata_out = wdata_in;
      end
    endcase
    unique case (funct3)
      F3_B:    rdata_out = {{24{lane[7]}}, lane[7:0]};
      F3_BU:   rdata_out = {24'h0, lane[7:0]};
      F3_H:    rdata_out = {{16{lane[15]}}, lane[15:0]};
      F3_HU:   rdata_out = {16'h0, lane[15:0]};
      default: rdata_out = lane;
    endcase
  end

endmodule

// File: rtl/dmem_lsu.sv
// MEM-stage load/store unit: single-outstanding req/gnt/rvalid initiator with
// pipeline stall, load alignment and error reporting (misalign/timeout/illegal).
// LSU_MISALIGN_TRAP_EN: misaligned h/w accesses trap instead of being force-aligned.
module dmem_lsu
  import lsu_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ex_valid,
  input  logic        ex_is_load,
  input  logic        ex_is_store,
  input  logic [2:0]  ex_funct3,
  input  logic [31:0] ex_addr,
  input  logic [31:0] ex_wdata,
  output logic        lsu_stall,
  output logic        wb_valid,
  output logic [31:0] wb_rdata,
  output logic        lsu_err,
  output logic [1:0]  lsu_err_cause,
  output logic        mem_req,
  output logic        mem_we,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata
);

  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYCLES - 1);

  lsu_state_e  state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic        mem_req_q, mem_req_d, mem_we_q, mem_we_d;
  logic [3:0]  mem_be_q, mem_be_d;
  logic [31:0] mem_addr_q, mem_addr_d, mem_wdata_q, mem_wdata_d;
  logic        wb_valid_q, wb_valid_d, err_q, err_d;
  logic [31:0] wb_rdata_q, wb_rdata_d;
  logic [1:0]  cause_q, cause_d;
  logic [2:0]  f3_q, f3_d;
  logic [1:0]  off_q, off_d;

  logic        accept;
  logic [2:0]  al_f3;
  logic [1:0]  al_off;
  logic [3:0]  al_be;
  logic [31:0] al_wdata, al_rdata;
  logic        al_illegal, al_misaligned;

  assign accept    = ex_valid && (ex_is_load || ex_is_store);
  assign lsu_stall = ((state_q == StIdle) && accept) || (state_q == StReq) ||
                     (state_q == StWait);

  // Live EX operands while accepting; latched copies once the access is in flight
  assign al_f3  = (state_q == StIdle) ? ex_funct3    : f3_q;
  assign al_off = (state_q == StIdle) ? ex_addr[1:0] : off_q;

  lsu_align u_align (
    .funct3     (al_f3),
    .off        (al_off),
    .is_store   (ex_is_store),
    .wdata_in   (ex_wdata),
    .rdata_in   (mem_rdata),
    .be         (al_be),
    .wdata_out  (al_wdata),
    .rdata_out  (al_rdata),
    .illegal    (al_illegal),
    .misaligned (al_misaligned)
  );

  // Next-state, timeout counter and registered output computation
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_be_d    = mem_be_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    wb_valid_d  = 1'b0;
    wb_rdata_d  = wb_rdata_q;
    err_d       = 1'b0;
    cause_d     = CAUSE_NONE;
    f3_d        = f3_q;
    off_d       = off_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          mem_addr_d  = {ex_addr[31:2], 2'b00};
          mem_we_d    = ex_is_store;
          mem_be_d    = al_be;
          mem_wdata_d = al_wdata;
          f3_d        = ex_funct3;
          off_d       = ex_addr[1:0];
          if (al_illegal) begin
            state_d = StDone;
            err_d   = 1'b1;
            cause_d = CAUSE_ILLEGAL;
          end else if (al_misaligned) begin
            state_d = StDone;
            err_d   = 1'b1;
            cause_d = CAUSE_MISALIGN;
          end else begin
            state_d   = StReq;
            mem_req_d = 1'b1;
            cnt_d     = '0;
          end
        end
      end
      StReq: begin
        cnt_d = cnt_q + 1'b1;
        if (mem_gnt) begin
          state_d   = StWait;
          mem_req_d = 1'b0;
        end else if (cnt_q == CntLast) begin
          state_d   = StDone;
          mem_req_d = 1'b0;
          err_d     = 1'b1;
          cause_d   = CAUSE_TIMEOUT;
        end
      end
      StWait: begin
        cnt_d = cnt_q + 1'b1;
        if (mem_rvalid) begin
          state_d = StDone;
          if (!mem_we_q) begin
            wb_valid_d = 1'b1;
            wb_rdata_d = al_rdata;
          end
        end else if (cnt_q == CntLast) begin
          state_d = StDone;
          err_d   = 1'b1;
          cause_d = CAUSE_TIMEOUT;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // FSM state and registered outputs, synchronous active-high reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_be_q    <= 4'b0000;
      mem_addr_q  <= 32'h0;
      mem_wdata_q <= 32'h0;
      wb_valid_q  <= 1'b0;
      wb_rdata_q  <= 32'h0;
      err_q       <= 1'b0;
      cause_q     <= CAUSE_NONE;
      f3_q        <= 3'b000;
      off_q       <= 2'b00;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_be_q    <= mem_be_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      wb_valid_q  <= wb_valid_d;
      wb_rdata_q  <= wb_rdata_d;
      err_q       <= err_d;
      cause_q     <= cause_d;
      f3_q        <= f3_d;
      off_q       <= off_d;
    end
  end

  assign mem_req       = mem_req_q;
  assign mem_we        = mem_we_q;
  assign mem_be        = mem_be_q;
  assign mem_addr      = mem_addr_q;
  assign mem_wdata     = mem_wdata_q;
  assign wb_valid      = wb_valid_q;
  assign wb_rdata      = wb_rdata_q;
  assign lsu_err       = err_q;
  assign lsu_err_cause = cause_q;

endmodule

// File: tb/tb_dmem_lsu.sv
// Scoreboard bench for dmem_lsu: expected requests and responses are queued
// by the stimulus; a memory model and a response monitor pop and compare.
module tb_dmem_lsu;

  logic        clk = 1'b0;
  logic        reset;
  logic        ex_valid, ex_is_load, ex_is_store;
  logic [2:0]  ex_funct3;
  logic [31:0] ex_addr, ex_wdata;
  logic        lsu_stall, wb_valid, lsu_err;
  logic [31:0] wb_rdata;
  logic [1:0]  lsu_err_cause;
  logic        mem_req, mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_gnt, mem_rvalid;
  logic [31:0] mem_rdata;

  always #5 clk = ~clk;

  dmem_lsu #(.TIMEOUT_CYCLES(16)) dut (
    .clk           (clk),
    .reset         (reset),
    .ex_valid      (ex_valid),
    .ex_is_load    (ex_is_load),
    .ex_is_store   (ex_is_store),
    .ex_funct3     (ex_funct3),
    .ex_addr       (ex_addr),
    .ex_wdata      (ex_wdata),
    .lsu_stall     (lsu_stall),
    .wb_valid      (wb_valid),
    .wb_rdata      (wb_rdata),
    .lsu_err       (lsu_err),
    .lsu_err_cause (lsu_err_cause),
    .mem_req       (mem_req),
    .mem_we        (mem_we),
    .mem_be        (mem_be),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
    .mem_gnt       (mem_gnt),
    .mem_rvalid    (mem_rvalid),
    .mem_rdata     (mem_rdata)
  );

  typedef struct {
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        chk_wdata;
  } req_t;

  typedef struct {
    logic        is_err;
    logic [31:0] data;
    logic [1:0]  cause;
  } resp_t;

  req_t  req_q[$];
  resp_t exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;
  int exp_events = 0;
  int mon_events = 0;

  // Memory model controls
  int          gnt_delay = 0;
  logic        resp_en   = 1'b1;
  logic [31:0] rdata_val = 32'h0;
  logic        stray     = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  task automatic push_req(input logic we, input logic [3:0] be, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic chk_wdata);
    req_t r;
    r.we = we; r.be = be; r.addr = addr; r.wdata = wdata; r.chk_wdata = chk_wdata;
    req_q.push_back(r);
  endtask

  task automatic push_wb(input logic [31:0] data);
    resp_t r;
    r.is_err = 1'b0; r.data = data; r.cause = 2'b00;
    exp_q.push_back(r);
    exp_events++;
  endtask

  task automatic push_err(input logic [1:0] cause);
    resp_t r;
    r.is_err = 1'b1; r.data = 32'h0; r.cause = cause;
    exp_q.push_back(r);
    exp_events++;
  endtask

  // Memory model: checks each new request against req_q, grants after gnt_delay
  // cycles, responds the cycle after the grant.
  initial begin
    int   age;
    logic pend;
    req_t r;
    age = 0; pend = 1'b0;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h0;
    forever begin
      @(posedge clk); #1;
      mem_gnt = 1'b0; mem_rvalid = 1'b0;
      if (pend) begin
        mem_rvalid = resp_en;
        mem_rdata  = rdata_val;
        pend       = 1'b0;
      end
      if (stray) begin
        mem_rvalid = 1'b1;
        mem_rdata  = 32'hFFFF_FFFF;
        stray      = 1'b0;
      end
      if (mem_req) begin
        if (age == 0) begin
          if (req_q.size() == 0) begin
            n_checks++; n_fail++;
            $display("FAIL unexpected_req: got mem_req=1 addr=%h required no request", mem_addr);
          end else begin
            r = req_q.pop_front();
            check("req_we", 32'(mem_we), 32'(r.we));
            check("req_be", 32'(mem_be), 32'(r.be));
            check("req_addr", mem_addr, r.addr);
            if (r.chk_wdata) check("req_wdata", mem_wdata, r.wdata);
          end
        end
        if (age == gnt_delay) begin
          mem_gnt = 1'b1;
          pend    = 1'b1;
        end
        age++;
      end else begin
        age = 0;
      end
    end
  end

  // Response monitor
  always @(negedge clk) begin
    resp_t r;
    if (!reset && (wb_valid || lsu_err)) begin
      mon_events++;
      if (exp_q.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL unexpected_resp: got wb_valid=%b lsu_err=%b required none",
                 wb_valid, lsu_err);
      end else begin
        r = exp_q.pop_front();
        check("resp_err", 32'(lsu_err), 32'(r.is_err));
        check("resp_wb_valid", 32'(wb_valid), 32'(!r.is_err));
        if (r.is_err) check("err_cause", 32'(lsu_err_cause), 32'(r.cause));
        else          check("wb_rdata", wb_rdata, r.data);
      end
    end
  end

  task automatic do_op(input logic ld, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wdata, input int exp_stall);
    int stall_n;
    @(posedge clk); #1;
    ex_valid = 1'b1; ex_is_load = ld; ex_is_store = !ld;
    ex_funct3 = f3; ex_addr = addr; ex_wdata = wdata;
    #1;
    stall_n = lsu_stall ? 1 : 0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      if (!lsu_stall) break;
      stall_n++;
    end
    ex_valid = 1'b0; ex_is_load = 1'b0; ex_is_store = 1'b0;
    check("stall_cycles", 32'(stall_n), 32'(exp_stall));
    @(negedge clk); #1;
    check("resp_drained", 32'(exp_q.size()), 32'd0);
    check("req_drained", 32'(req_q.size()), 32'd0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_mem_req"}, 32'(mem_req), 32'd0);
    check({tag, "_mem_we"}, 32'(mem_we), 32'd0);
    check({tag, "_mem_be"}, 32'(mem_be), 32'd0);
    check({tag, "_mem_addr"}, mem_addr, 32'd0);
    check({tag, "_mem_wdata"}, mem_wdata, 32'd0);
    check({tag, "_wb_valid"}, 32'(wb_valid), 32'd0);
    check({tag, "_wb_rdata"}, wb_rdata, 32'd0);
    check({tag, "_lsu_err"}, 32'(lsu_err), 32'd0);
    check({tag, "_err_cause"}, 32'(lsu_err_cause), 32'd0);
    check({tag, "_stall"}, 32'(lsu_stall), 32'd0);
  endtask

  initial begin
    reset = 1'b1;
    ex_valid = 1'b0; ex_is_load = 1'b0; ex_is_store = 1'b0;
    ex_funct3 = 3'b000; ex_addr = 32'h0; ex_wdata = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    reset = 1'b0;

    // Stores
    push_req(1'b1, 4'b1111, 32'h100, 32'hDEADBEEF, 1'b1);
    do_op(1'b0, 3'b010, 32'h100, 32'hDEADBEEF, 3);
    push_req(1'b1, 4'b1000, 32'h100, 32'hA5A5A5A5, 1'b1);
    do_op(1'b0, 3'b000, 32'h103, 32'h000000A5, 3);
    push_req(1'b1, 4'b1100, 32'h200, 32'h12341234, 1'b1);
    do_op(1'b0, 3'b001, 32'h202, 32'hCAFE1234, 3);

    // Loads against 0x80F17F82
    rdata_val = 32'h80F17F82;
    push_req(1'b0, 4'b0100, 32'h100, 32'h0, 1'b0); push_wb(32'hFFFFFFF1);
    do_op(1'b1, 3'b000, 32'h102, 32'h0, 3);
    push_req(1'b0, 4'b1000, 32'h100, 32'h0, 1'b0); push_wb(32'h00000080);
    do_op(1'b1, 3'b100, 32'h103, 32'h0, 3);
    push_req(1'b0, 4'b0011, 32'h100, 32'h0, 1'b0); push_wb(32'h00007F82);
    do_op(1'b1, 3'b001, 32'h100, 32'h0, 3);
    push_req(1'b0, 4'b1100, 32'h100, 32'h0, 1'b0); push_wb(32'h000080F1);
    do_op(1'b1, 3'b101, 32'h102, 32'h0, 3);
    push_req(1'b0, 4'b1111, 32'h100, 32'h0, 1'b0); push_wb(32'h80F17F82);
    do_op(1'b1, 3'b010, 32'h100, 32'h0, 3);

    // Misaligned word
`ifdef LSU_MISALIGN_TRAP_EN
    push_err(2'b01);
    do_op(1'b1, 3'b010, 32'h102, 32'h0, 1);
`else
    push_req(1'b0, 4'b1111, 32'h100, 32'h0, 1'b0); push_wb(32'h80F17F82);
    do_op(1'b1, 3'b010, 32'h102, 32'h0, 3);
`endif

    // Illegal funct3: store with unsigned code, load with 011
    push_err(2'b11);
    do_op(1'b0, 3'b100, 32'h100, 32'h55, 1);
    push_err(2'b11);
    do_op(1'b1, 3'b011, 32'h100, 32'h0, 1);

    // Delayed grant
    gnt_delay = 3;
    push_req(1'b0, 4'b0010, 32'h100, 32'h0, 1'b0); push_wb(32'h0000007F);
    do_op(1'b1, 3'b000, 32'h101, 32'h0, 6);

    // Timeout: grant withheld for the whole budget
    gnt_delay = 1000;
    push_req(1'b0, 4'b1111, 32'h300, 32'h0, 1'b0); push_err(2'b10);
    do_op(1'b1, 3'b010, 32'h300, 32'h0, 17);
    check("timeout_req_dropped", 32'(mem_req), 32'd0);
    gnt_delay = 0;
    // Late stray response must be ignored
    stray = 1'b1;
    repeat (3) @(posedge clk);
    check("stray_events", 32'(mon_events), 32'(exp_events));

    // Reset while waiting for the response
    resp_en = 1'b0;
    push_req(1'b0, 4'b1111, 32'h104, 32'h0, 1'b0);
    @(posedge clk); #1;
    ex_valid = 1'b1; ex_is_load = 1'b1; ex_funct3 = 3'b010; ex_addr = 32'h104;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b1;
    ex_valid = 1'b0; ex_is_load = 1'b0;
    @(posedge clk); #1;
    check_all_zero("midreset");
    reset = 1'b0;
    resp_en = 1'b1;
    check("midreset_req_seen", 32'(req_q.size()), 32'd0);

    // Normal load after the reset
    rdata_val = 32'h13579BDF;
    push_req(1'b0, 4'b1111, 32'h104, 32'h0, 1'b0); push_wb(32'h13579BDF);
    do_op(1'b1, 3'b010, 32'h104, 32'h0, 3);

    repeat (2) @(posedge clk);
    check("total_events", 32'(mon_events), 32'(exp_events));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dmem_lsu.md
# dmem_lsu

Load/store unit that acts as the initiator toward the data memory in the MEM stage of the 5-stage RISC-V pipeline. It accepts one load or store per instruction from the EX/MEM register and drives a single-outstanding req/gnt/rvalid memory port with byte enables. It aligns and sign-extends load data, replicates store data, and stalls the pipeline until the access completes. Misaligned accesses, illegal funct3 values and unresponsive memory are reported as errors.

## Interface
- TIMEOUT_CYCLES, 16, max cycles spent in REQ+WAIT before a timeout error (≥2)
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- ex_valid  in  1  instruction in MEM stage is valid
- ex_is_load / ex_is_store  in  1 each  memory op type (mutually exclusive)
- ex_funct3  in  3  RISC-V width code
- ex_addr  in  32  byte address
- ex_wdata  in  32  store data (rs2)
- lsu_stall  out  1  hold pipeline
- wb_valid  out  1  one-cycle pulse; wb_rdata is valid (loads only)
- wb_rdata  out  32  extended load result
- lsu_err  out  1  one-cycle error pulse
- lsu_err_cause  out  2  01 misaligned, 10 timeout, 11 illegal funct3
- mem_req  out  1  request valid
- mem_we  out  1  1 = store
- mem_be  out  4  byte enables
- mem_addr  out  32  word address, {ex_addr[31:2],2'b00}
- mem_wdata  out  32  lane-replicated store data
- mem_gnt  in  1  request accepted
- mem_rvalid  in  1  response (read data or store ack)
- mem_rdata  in  32  read data

## Operation
- FSM states: IDLE, REQ, WAIT, DONE.
- IDLE: when ex_valid && (ex_is_load || ex_is_store), the op is accepted. Address, be, we and wdata are latched.
  - Legal op: go to REQ.
  - Illegal funct3 or misaligned (trap build): go to DONE with the error latched; no memory request is issued.
- REQ: mem_req=1. Address, we, be and wdata stay stable until mem_gnt. On mem_gnt, go to WAIT.
- WAIT: mem_req=0. On mem_rvalid, latch the extended mem_rdata and go to DONE.
- DONE: lsu_stall=0. For a successful load, wb_valid=1. On error, lsu_err=1. Next state is always IDLE. No accept happens in DONE; the pipeline advances during this cycle.
- lsu_stall = (IDLE && accept) || REQ || WAIT.
- funct3 encoding: 000 b, 001 h, 010 w, 100 bu, 101 hu. Loads accept all five codes; stores accept 000/001/010 only; anything else is illegal.
- off = ex_addr[1:0].
  - Byte: be = 0001<<off; wdata = {4{wdata[7:0]}}.
  - Half: be = 0011<<off; wdata = {2{wdata[15:0]}}.
  - Word: be = 1111.
  - Load mem_be equals the access's byte enables.
- Load extract: lane = mem_rdata >> (8*off). lb/lh sign-extend, lbu/lhu zero-extend, lw is passed through.
- Timeout: a counter clears on entry to REQ and increments each cycle in REQ/WAIT. If it reaches TIMEOUT_CYCLES without the awaited gnt/rvalid, go to DONE with cause 10 and drop mem_req. An rvalid arriving outside WAIT is ignored.
- gnt outside REQ is ignored. rvalid in the same cycle as gnt is not a response; the memory responds no earlier than the cycle after gnt.

## Timing
- Reset: state=IDLE. All outputs 0: lsu_stall, wb_valid, wb_rdata, lsu_err, lsu_err_cause, mem_req, mem_we, mem_be, mem_addr, mem_wdata. The timeout counter is cleared.
- Reset mid-op: mem_req is low after the reset edge. Any pending response is discarded.
- All mem_* and wb_*/lsu_err outputs are registered. lsu_stall is combinational.
- Latency, accept in cycle 0 with gnt in the first REQ cycle and rvalid one cycle later:
  - cycle 1: mem_req
  - cycle 2: WAIT, rvalid sampled
  - cycle 3: DONE, wb_valid
  - Stall covers cycles 0–2.
- Error without memory access: stall in cycle 0 only; DONE with lsu_err in cycle 1.
- Back-to-back ops: the next accept occurs earliest the cycle after DONE.

## Configuration
- LSU_MISALIGN_TRAP_EN defined: a misaligned access (h with off[0]=1, w with off≠0) produces cause 01 and issues no request.
- LSU_MISALIGN_TRAP_EN undefined: the offset is force-aligned and the access proceeds without error.
  - h uses off & 2'b10.
  - w uses off 0.

## Structure
- Package lsu_pkg holds:
  - the state enum
  - funct3 localparams (F3_B, F3_H, F3_W, F3_BU, F3_HU)
  - cause codes (CAUSE_MISALIGN, CAUSE_TIMEOUT, CAUSE_ILLEGAL)
- Sub-module lsu_align: combinational be/wdata generation and load extraction, shared by both directions. The FSM and timeout counter stay in dmem_lsu.

## Test plan
- sw at 0x100, wdata 0xDEADBEEF, gnt in the first cycle, rvalid next: mem_be=1111, mem_addr=0x100, mem_we=1; stall for 3 cycles; no wb_valid.
- sb at 0x103, wdata 0x000000A5: mem_be=1000, mem_wdata=0xA5A5A5A5, mem_addr=0x100.
- Loads with mem_rdata=0x80F17F82:
  - lb at 0x102 gives 0xFFFFFFF1.
  - lbu at 0x103 gives 0x00000080.
  - lh at 0x100 gives 0x00007F82.
  - lhu at 0x102 gives 0x000080F1.
- lw at 0x102: with the trap macro, lsu_err=1, cause 01, mem_req never rises. Without it, mem_addr=0x100 and the full word is returned.
- gnt withheld (TIMEOUT_CYCLES=16): lsu_err with cause 10 in the DONE cycle; mem_req falls; a later rvalid is ignored.
- Reset asserted while in WAIT: outputs return to 0 the next cycle; the next lw completes normally.
